// File: rtl/render_done_tracker.sv
// Frame-completion tracker: counts worker pixel pulses against the frame total and times the render in clk cycles.
// Every output is registered, one cycle after the sampling edge; no backpressure, every pixel_done pulse is taken as it arrives.
module render_done_tracker #(
    parameter int NUM_WORKERS  = 4,
    parameter int TOTAL_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_WORKERS-1:0] pixel_done,
    output logic                   busy,
    output logic [CNT_W-1:0]       pixel_count,
    output logic [31:0]            finish_render
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W:0] TOTAL_W = (CNT_W+1)'(TOTAL_PIXELS);
    localparam logic [29:0]    CYC_MAX = '1;

    state_t           r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_pixel_count;
    logic             r_done;
    logic             r_overrun;
    logic [29:0]      r_cycles;

    logic [CNT_W:0]   w_inc;
    logic [CNT_W:0]   w_sum;
    logic             w_any_px;

    // Sum is one bit wider than the counter so a multi-worker burst past the threshold is never lost.
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            w_inc = w_inc + {{CNT_W{1'b0}}, pixel_done[i]};
        end
        w_sum    = {1'b0, r_pixel_count} + w_inc;
        w_any_px = |pixel_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_pixel_count <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_cycles      <= '0;
        end else if (start) begin
            // Start restarts from any state; pixel_done in this cycle is dropped.
            r_state       <= S_RUN;
            r_busy        <= 1'b1;
            r_pixel_count <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_cycles      <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cycles != CYC_MAX) begin
                        r_cycles <= r_cycles + 30'd1;
                    end
                    if (w_sum >= TOTAL_W) begin
                        r_pixel_count <= TOTAL_W[CNT_W-1:0];
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                        if (w_sum > TOTAL_W) begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_pixel_count <= w_sum[CNT_W-1:0];
                    end
                end
                S_DONE: begin
                    if (w_any_px) begin
                        r_overrun <= 1'b1;
                    end
                end
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign pixel_count   = r_pixel_count;
    assign finish_render = {r_done, r_overrun, r_cycles};

endmodule

// File: tb/tb_render_done_tracker.sv
// Bench for render_done_tracker: two instances (8 and 10 pixel frames) share stimulus and are
// compared against directed expectations and a per-edge behavioural model under random traffic.
module tb_render_done_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  pd;

    logic        busy8, busy10;
    logic [18:0] cnt8, cnt10;
    logic [31:0] fr8, fr10;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: 0 idle, 1 run, 2 done
    int m_state [2];
    int m_cnt   [2];
    int m_cyc   [2];
    bit m_done  [2];
    bit m_ov    [2];

    always #5 clk = ~clk;

    render_done_tracker #(.NUM_WORKERS(4), .TOTAL_PIXELS(8), .CNT_W(19)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .pixel_done(pd),
        .busy(busy8), .pixel_count(cnt8), .finish_render(fr8)
    );

    render_done_tracker #(.NUM_WORKERS(4), .TOTAL_PIXELS(10), .CNT_W(19)) u_dut10 (
        .clk(clk), .reset(reset), .start(start), .pixel_done(pd),
        .busy(busy10), .pixel_count(cnt10), .finish_render(fr10)
    );

    task automatic model_step(input int d);
        int total;
        int s;
        total = (d == 0) ? 8 : 10;
        if (reset) begin
            m_state[d] = 0; m_cnt[d] = 0; m_cyc[d] = 0; m_done[d] = 0; m_ov[d] = 0;
        end else if (start) begin
            m_state[d] = 1; m_cnt[d] = 0; m_cyc[d] = 0; m_done[d] = 0; m_ov[d] = 0;
        end else if (m_state[d] == 1) begin
            s = m_cnt[d] + $countones(pd);
            if (m_cyc[d] < (1 << 30) - 1) m_cyc[d] = m_cyc[d] + 1;
            if (s >= total) begin
                m_cnt[d]   = total;
                m_done[d]  = 1;
                m_state[d] = 2;
                if (s > total) m_ov[d] = 1;
            end else begin
                m_cnt[d] = s;
            end
        end else if (m_state[d] == 2) begin
            if (pd != 4'h0) m_ov[d] = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; pd = 4'hF;
        repeat (3) cycle();
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd0, 32'h0})
            $display("FAIL reset_dut8: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=0 fr=00000000", busy8, cnt8, fr8);
        else n_pass++;
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b0, 19'd0, 32'h0})
            $display("FAIL reset_dut10: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=0 fr=00000000", busy10, cnt10, fr10);
        else n_pass++;
        reset = 1'b0; start = 1'b0; pd = 4'h0;
        cycle();
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd0, 32'h0})
            $display("FAIL reset_idle_hold: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=0 fr=00000000", busy8, cnt8, fr8);
        else n_pass++;
    endtask

    task automatic test_nominal();
        start = 1'b1; pd = 4'h0;
        cycle();
        start = 1'b0;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b1, 19'd0, 32'h0})
            $display("FAIL nominal_start: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=0 fr=00000000", busy8, cnt8, fr8);
        else n_pass++;
        pd = 4'hF;
        cycle();
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b1, 19'd4, 32'h1})
            $display("FAIL nominal_px4: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=4 fr=00000001", busy8, cnt8, fr8);
        else n_pass++;
        cycle();
        pd = 4'h0;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd8, 32'h80000002})
            $display("FAIL nominal_done: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=8 fr=80000002", busy8, cnt8, fr8);
        else n_pass++;
        repeat (2) cycle();
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd8, 32'h80000002})
            $display("FAIL nominal_hold: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=8 fr=80000002", busy8, cnt8, fr8);
        else n_pass++;
    endtask

    task automatic test_clamp_overrun();
        start = 1'b1; pd = 4'h0;
        cycle();
        start = 1'b0; pd = 4'hF;
        repeat (3) cycle();
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b0, 19'd10, 32'hC0000003})
            $display("FAIL clamp_dut10: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=10 fr=C0000003", busy10, cnt10, fr10);
        else n_pass++;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd8, 32'hC0000002})
            $display("FAIL clamp_dut8: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=8 fr=C0000002", busy8, cnt8, fr8);
        else n_pass++;
        pd = 4'h1;
        cycle();
        pd = 4'h0;
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b0, 19'd10, 32'hC0000003})
            $display("FAIL clamp_done_pulse: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=10 fr=C0000003", busy10, cnt10, fr10);
        else n_pass++;
    endtask

    task automatic test_restart();
        start = 1'b1; pd = 4'h3;
        cycle();
        start = 1'b0; pd = 4'h0;
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b1, 19'd0, 32'h0})
            $display("FAIL restart_clear: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=0 fr=00000000", busy10, cnt10, fr10);
        else n_pass++;
        repeat (5) cycle();
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b1, 19'd0, 32'h5})
            $display("FAIL restart_idle5: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=0 fr=00000005", busy10, cnt10, fr10);
        else n_pass++;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b1, 19'd0, 32'h5})
            $display("FAIL restart_idle5_dut8: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=0 fr=00000005", busy8, cnt8, fr8);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        start = 1'b1; pd = 4'h0;
        cycle();
        start = 1'b0; pd = 4'b0111;
        cycle();
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b1, 19'd3, 32'h1})
            $display("FAIL midreset_pre: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=3 fr=00000001", busy10, cnt10, fr10);
        else n_pass++;
        reset = 1'b1; pd = 4'h0;
        cycle();
        reset = 1'b0;
        n_checks++;
        if ({busy10, cnt10, fr10} !== {1'b0, 19'd0, 32'h0})
            $display("FAIL midreset_clear: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=0 fr=00000000", busy10, cnt10, fr10);
        else n_pass++;
        pd = 4'hF;
        repeat (3) cycle();
        pd = 4'h0;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd0, 32'h0})
            $display("FAIL midreset_idle_px: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=0 fr=00000000", busy8, cnt8, fr8);
        else n_pass++;
    endtask

    task automatic test_sparse();
        start = 1'b1; pd = 4'h0;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            pd = (k % 2 == 1) ? 4'b0101 : 4'b0000;
            cycle();
        end
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b1, 19'd6, 32'h6})
            $display("FAIL sparse_edge6: got busy=%0b cnt=%0d fr=%h want busy=1 cnt=6 fr=00000006", busy8, cnt8, fr8);
        else n_pass++;
        pd = 4'b0101;
        cycle();
        pd = 4'h0;
        n_checks++;
        if ({busy8, cnt8, fr8} !== {1'b0, 19'd8, 32'h80000007})
            $display("FAIL sparse_done: got busy=%0b cnt=%0d fr=%h want busy=0 cnt=8 fr=80000007", busy8, cnt8, fr8);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [51:0] exp_v;
        logic [51:0] act_v;
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 24) == 0);
            pd    = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            cycle();
            for (int d = 0; d < 2; d++) begin
                exp_v = {(m_state[d] == 1), 19'(m_cnt[d]), m_done[d], m_ov[d], 30'(m_cyc[d])};
                act_v = (d == 0) ? {busy8, cnt8, fr8} : {busy10, cnt10, fr10};
                n_checks++;
                if (act_v !== exp_v)
                    $display("FAIL random_dut%0d cycle %0d: got busy=%0b cnt=%0d fr=%h want busy=%0b cnt=%0d fr=%h",
                             d, n, act_v[51], act_v[50:32], act_v[31:0], exp_v[51], exp_v[50:32], exp_v[31:0]);
                else n_pass++;
            end
        end
        reset = 1'b0; start = 1'b0; pd = 4'h0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pd = 4'h0;
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_cnt[d] = 0; m_cyc[d] = 0; m_done[d] = 0; m_ov[d] = 0;
        end
        test_reset();
        test_nominal();
        test_clamp_overrun();
        test_restart();
        test_midframe_reset();
        test_sparse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/render_done_tracker.md
Name: render_done_tracker

Overview:
- Upstream of the finish_render PIO input port: produces the 32-bit status word the HPS polls to learn that a Mandelbrot frame is complete.
- Counts pixel-completion pulses from the parallel solver workers against the frame pixel total.
- Measures render time in clock cycles and flags protocol overruns.
- finish_render output wires directly to the PIO in_port.

Parameters:
- NUM_WORKERS, 4, number of solver workers, one pixel_done bit each (1..16).
- TOTAL_PIXELS, 307200, pixels per frame (640x480); completion threshold.
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > TOTAL_PIXELS + NUM_WORKERS.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse from HPS control PIO; begins or restarts frame accounting
- pixel_done  in  NUM_WORKERS  per-worker pulse, 1 = that worker wrote one pixel this cycle
- busy  out  1  1 while in RUN
- pixel_count  out  CNT_W  pixels counted in current/last frame
- finish_render  out  32  [31]=done, [30]=overrun, [29:0]=elapsed RUN cycles

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset (clk edge with reset=1), overriding every other input:
  - state=IDLE
  - busy=0, pixel_count=0, finish_render=0
- States:
  - IDLE: start=1 -> RUN; counters, done and overrun clear on that edge. pixel_done ignored.
  - RUN: each edge:
    - inc = popcount(pixel_done), range 0..NUM_WORKERS.
    - sum = pixel_count + inc, computed at CNT_W+1 bits.
    - cycles field +1, saturating at 2^30-1.
    - If sum >= TOTAL_PIXELS: pixel_count <= TOTAL_PIXELS; done <= 1; state <= DONE. If sum > TOTAL_PIXELS, overrun <= 1.
    - Else pixel_count <= sum.
  - DONE: all fields hold. Any pixel_done bit = 1 sets overrun (sticky); pixel_count and cycles do not change. start=1 -> RUN with clear.
- start in RUN restarts: counters, done and overrun clear, state stays RUN. pixel_done sampled in the same cycle as start is discarded.
- start and reset in the same cycle: reset wins.
- Cycle accounting:
  - cycles equals the number of RUN-state edges up to and including the completing edge.
  - start sampled at edge k and completion sampled at edge k+m gives cycles = m.
- Latency: busy rises 1 cycle after start is sampled. done, pixel_count and cycles are visible the cycle after the completing edge. busy falls in that same cycle.
- finish_render[29:0] updates live during RUN.
- TOTAL_PIXELS reachable with a single-cycle multi-bit pulse: the threshold compare uses the full sum, never equality.

Test Plan:
- Reset: hold reset 3 cycles with start=1 and pixel_done=4'hF -> finish_render=0x00000000, busy=0, pixel_count=0, state IDLE.
- Nominal (TOTAL_PIXELS=8, NUM_WORKERS=4): start pulse, then pixel_done=4'hF for 2 cycles, then 0 -> busy 1 then 0, pixel_count=8, finish_render=0x80000002.
- Clamp and overrun (TOTAL_PIXELS=10): start, 4'hF, 4'hF, 4'hF -> pixel_count=10, finish_render=0xC0000003. Then 4'h1 in DONE -> overrun stays 1, count stays 10.
- Restart: in DONE, pulse start with pixel_done=4'h3 in the same cycle -> next cycle finish_render=0x00000000, pixel_count=0, busy=1. Idle workers for 5 cycles -> finish_render=0x00000005.
- Mid-frame reset: after start and 3 pixels, assert reset 1 cycle -> all outputs 0, IDLE. Subsequent pixel_done=4'hF without start -> pixel_count stays 0.
- Sparse pulses (TOTAL_PIXELS=8): start, then alternating pixel_done=4'b0101 and 0 -> completes on the 7th RUN cycle with finish_render=0x80000007, overrun=0.
